// File: rtl/fsm_decode_ref.sv
// Receive-side decode sequencer: captures the shifted word and the pass-through word,
// undoes the encoder's unshift/add/subtract chain and emits the operand pair with a done pulse.
module fsm_decode_ref #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             done,
  output logic             err
);

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    CAP1    = 3'd1,
    CAP2    = 3'd2,
    UNSHIFT = 3'd3,
    ADD     = 3'd4,
    SUB     = 3'd5,
    EMIT1   = 3'd6,
    EMIT2   = 3'd7
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] r1, r1_nx;
  logic [WIDTH-1:0] r2, r2_nx;
  logic [WIDTH-1:0] a_nx, b_nx;
  logic             done_nx, err_nx;

  // State and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      r1    <= '0;
      r2    <= '0;
      a_out <= '0;
      b_out <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      r1    <= r1_nx;
      r2    <= r2_nx;
      a_out <= a_nx;
      b_out <= b_nx;
      done  <= done_nx;
      err   <= err_nx;
    end
  end

  // Next-state and register-update decode; every register holds unless its state acts on it
  always_comb begin
    state_nx = IDLE;
    r1_nx    = r1;
    r2_nx    = r2;
    a_nx     = a_out;
    b_nx     = b_out;
    done_nx  = done;
    err_nx   = err;

    case (state)
      IDLE: begin
        done_nx = 1'b0;
        if (start) begin
          err_nx   = 1'b0;
          state_nx = CAP1;
        end else begin
          state_nx = IDLE;
        end
      end
      CAP1: begin
        r1_nx    = data_in;
        state_nx = CAP2;
      end
      CAP2: begin
        r2_nx    = data_in;
        state_nx = UNSHIFT;
      end
      UNSHIFT: begin
        // A set LSB cannot come from a left shift, so flag the word as malformed
        r1_nx    = r1 >> 1;
        err_nx   = r1[0];
        state_nx = ADD;
      end
      ADD: begin
        r1_nx    = WIDTH'(r1 + r2);
        state_nx = SUB;
      end
      SUB: begin
        r1_nx    = WIDTH'(r1 - r2);
        state_nx = EMIT1;
      end
      EMIT1: begin
        a_nx     = r1;
        state_nx = EMIT2;
      end
      EMIT2: begin
        b_nx     = r2;
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fsm_decode_ref.sv
// Scoreboard bench for fsm_decode_ref: the driver pushes expected results per transaction,
// a monitor pops and compares them whenever done is presented.
module tb_fsm_decode_ref;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             done;
  logic             err;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             e;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic done_prev = 1'b0;

  fsm_decode_ref #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data_in (data_in),
    .a_out   (a_out),
    .b_out   (b_out),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: the decoder recovers word1 shifted right, word2 unchanged, err from word1 LSB
  function automatic exp_t model(input logic [WIDTH-1:0] w1, input logic [WIDTH-1:0] w2,
                                 input int c0);
    exp_t r;
    int   av;
    av    = int'(w1) / 2;
    av    = (av + int'(w2)) % 256;
    av    = (av - int'(w2) + 256) % 256;
    r.a   = WIDTH'(av);
    r.b   = w2;
    r.e   = (int'(w1) % 2) == 1;
    r.cyc = c0 + 8;
    return r;
  endfunction

  // Encoder side used for loopback: operand a goes out shifted, operand b passes through
  function automatic logic [WIDTH-1:0] encode_word1(input logic [WIDTH-1:0] a);
    return WIDTH'(int'(a) * 2);
  endfunction

  // Monitor: compares every done pulse against the oldest outstanding expectation
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (done) begin
        chk("done_width", 32'(done_prev), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("a_out", 32'(a_out), 32'(e.a));
          chk("b_out", 32'(b_out), 32'(e.b));
          chk("err", 32'(err), 32'(e.e));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  task automatic run_txn(input logic [WIDTH-1:0] w1, input logic [WIDTH-1:0] w2,
                         input bit hold, input bit sub_pulse);
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(model(w1, w2, cyc));
    @(negedge clk);
    chk("err_clear_on_start", 32'(err), 32'd0);
    start   = hold;
    data_in = w1;
    @(negedge clk);
    data_in = w2;
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk);
      data_in = WIDTH'($urandom);
      start   = (sub_pulse && k == 5) ? 1'b1 : hold;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start   = 1'b0;
      data_in = WIDTH'($urandom);
    end
  endtask

  // Reset asserted while the FSM is in ADD; the aborted transaction must never report
  task automatic reset_mid(input logic [WIDTH-1:0] w1, input logic [WIDTH-1:0] w2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    data_in = w1;
    @(negedge clk);
    data_in = w2;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_a_out", 32'(a_out), 32'd0);
    chk("rst_mid_b_out", 32'(b_out), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_a_out", 32'(a_out), 32'd0);
    chk("reset_b_out", 32'(b_out), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    idle(2);

    run_txn(8'h54, 8'h33, 1'b0, 1'b0);
    idle(3);
    run_txn(8'h55, 8'h10, 1'b0, 1'b0);
    idle(2);
    run_txn(8'hFE, 8'hFF, 1'b0, 1'b0);
    idle(2);
    run_txn(8'h02, 8'h01, 1'b1, 1'b0);
    run_txn(8'h80, 8'hAA, 1'b1, 1'b0);
    idle(3);

    run_txn(8'h55, 8'h77, 1'b0, 1'b0);
    idle(3);
    reset_mid(8'h9A, 8'h42);
    idle(12);
    run_txn(8'h3C, 8'hC3, 1'b0, 1'b1);
    idle(12);

    run_txn(encode_word1(8'h2A), 8'h33, 1'b0, 1'b0);
    idle(2);

    for (int i = 0; i < 24; i++) begin
      logic [WIDTH-1:0] w1, w2;
      bit               hold;
      w1   = WIDTH'($urandom);
      w2   = WIDTH'($urandom);
      hold = ($urandom_range(0, 3) == 0);
      run_txn(w1, w2, hold, 1'b0);
      if (!hold) idle(int'($urandom_range(0, 3)));
    end
    idle(2);

    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
